// File: rtl/fetch_queue_unit_pkg.sv
// Shared types for the fetch stage: queue entry layout and the bundle decode consumes.
package fetch_queue_unit_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_XLEN  = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] pc4;
  } fetch_entry_t;

  // Decode sees the queue head with exactly the entry layout.
  typedef fetch_entry_t fetch_bundle_t;

  function automatic fetch_entry_t make_entry(input logic [FETCH_XLEN-1:0] instr,
                                              input logic [FETCH_XLEN-1:0] pc);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc + FETCH_XLEN'(INSTR_BYTES);
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage registers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, queues responses for decode.
// Optional FETCH_PERF_COUNTERS_EN adds perf_fetched / perf_stall / perf_flush outputs.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW  = QCW + 1;
  localparam int EW  = 3 * XLEN;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [OCW-1:0]  drop_cnt_reg, drop_cnt_next;

  logic            q_push, q_pop, q_flush, q_full, q_empty;
  logic [QCW-1:0]  q_count;
  logic [EW-1:0]   q_wdata, q_rdata;

  logic            t_push, t_pop, t_full, t_empty;
  logic [OCW-1:0]  outstanding;
  logic [XLEN-1:0] t_rdata;

  logic            req_fire;
  logic            rsp_keep;
  logic [SW-1:0]   credit_used;

  // Outstanding plus queued never exceeds DEPTH, so every response finds a slot.
  assign credit_used    = SW'(outstanding) + SW'(q_count);
  assign imem_req_valid = !reset && !redirect_valid
                          && (credit_used < SW'(DEPTH))
                          && (outstanding < OCW'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop_cnt_reg == '0);

  assign q_push  = rsp_keep && !redirect_valid;
  assign q_pop   = out_valid && out_ready;
  assign q_flush = redirect_valid;
  assign t_push  = req_fire;
  assign t_pop   = imem_rsp_valid;

  assign out_valid = !reset && !q_empty;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    drop_cnt_next = drop_cnt_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      // Everything still in flight is stale; a response landing now is dropped too.
      drop_cnt_next = outstanding - OCW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      drop_cnt_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .pop_data  (q_rdata),
    .flush     (q_flush),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Tracking FIFO survives redirects: stale responses still retire their PCs.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_track (
    .clk       (clk),
    .reset     (reset),
    .push      (t_push),
    .push_data (fetch_pc_reg),
    .pop       (t_pop),
    .pop_data  (t_rdata),
    .flush     (1'b0),
    .full      (t_full),
    .empty     (t_empty),
    .count     (outstanding)
  );

  generate
    if (XLEN == FETCH_XLEN) begin : g_bundle
      fetch_bundle_t head;
      assign q_wdata   = make_entry(imem_rsp_instr, t_rdata);
      assign head      = fetch_bundle_t'(q_rdata);
      assign out_instr = head.instr;
      assign out_pc    = head.pc;
      assign out_pc4   = head.pc4;
    end else begin : g_flat
      assign q_wdata   = {imem_rsp_instr, t_rdata, t_rdata + XLEN'(INSTR_BYTES)};
      assign out_instr = q_rdata[3*XLEN-1:2*XLEN];
      assign out_pc    = q_rdata[2*XLEN-1:XLEN];
      assign out_pc4   = q_rdata[XLEN-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && t_empty));
      assert (!(req_fire && t_full));
      assert (!(q_push && q_full && !q_pop));
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_reg, perf_stall_reg, perf_flush_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
      perf_flush_reg   <= '0;
    end else begin
      if (q_pop && (perf_fetched_reg != '1))      perf_fetched_reg <= perf_fetched_reg + 1'b1;
      if (!out_valid && (perf_stall_reg != '1))   perf_stall_reg   <= perf_stall_reg + 1'b1;
      if (redirect_valid && (perf_flush_reg != '1)) perf_flush_reg <= perf_flush_reg + 1'b1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
  assign perf_flush   = perf_flush_reg;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: behavioural imem with fixed latency, scoreboard of expected PCs.
module tb_fetch_queue_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
  logic [31:0]     perf_flush;
`endif

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          delivered = 0;
  int          issued = 0;
  int          d0;
  logic [31:0] exp_req_pc;
  logic [31:0] sb_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] rnd;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] start);
    sb_q.delete();
    for (int i = 0; i < 256; i++) sb_q.push_back(start + 32'(4 * i));
    exp_req_pc = start;
  endtask

  // One clock: sample handshakes at negedge, then drive the memory response after the posedge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    if (reset) begin
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_req_valid", 32'(imem_req_valid), 32'd0);
      mem_addr_q.delete();
      mem_due_q.delete();
      load_stream(RESET_PC);
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_pc);
        exp_req_pc += 32'd4;
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc + lat);
        issued++;
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_underflow observed=%0d expected=nonzero", sb_q.size());
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("out_pc", out_pc, e);
          check("out_pc4", out_pc4, e + 32'd4);
          check("out_instr", out_instr, instr_of(e));
          $display("tb: deliver pc=%h instr=%h", out_pc, out_instr);
        end
        delivered++;
      end
      if (redirect_valid) load_stream(redirect_pc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      void'(mem_due_q.pop_front());
      imem_rsp_valid = 1'b1;
      imem_rsp_instr = instr_of(mem_addr_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_instr = '0;
    end
  endtask

  task automatic do_reset(input int l);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    lat            = l;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_instr = '0;
    out_ready      = 1'b1;
    #1;

    // Streaming at latency 1: one instruction per cycle after a 2-cycle fill.
    do_reset(1);
    out_ready = 1'b1;
    delivered = 0;
    repeat (12) cycle();
    check("t1_throughput", 32'(delivered), 32'd10);

    // Decode stall: exactly DEPTH requests issued, then none until released.
    do_reset(1);
    out_ready = 1'b0;
    issued = 0;
    delivered = 0;
    repeat (10) cycle();
    check("t2_issued", 32'(issued), 32'(DEPTH));
    check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    check("t2_head_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (6) cycle();
    check("t2_drained", 32'(delivered >= DEPTH), 32'd1);

    // Redirect with two requests in flight at latency 3.
    do_reset(3);
    out_ready = 1'b1;
    repeat (2) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    check("t3_out_valid_after_redirect", 32'(out_valid), 32'd0);
    delivered = 0;
    repeat (12) cycle();
    check("t3_delivered_after_redirect", 32'(delivered > 0), 32'd1);

    // Redirect coinciding with a response and a decode pop.
    do_reset(1);
    out_ready = 1'b1;
    repeat (6) cycle();
    check("t4_rsp_present", 32'(imem_rsp_valid), 32'd1);
    check("t4_head_present", 32'(out_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    d0 = delivered;
    cycle();
    redirect_valid = 1'b0;
    check("t4_pop_completed", 32'(delivered), 32'(d0 + 1));
    check("t4_out_valid_after_redirect", 32'(out_valid), 32'd0);
    repeat (8) cycle();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    d0 = delivered;
    repeat (8) cycle();
    check("t5_wrap_delivered", 32'(delivered - d0 >= 3), 32'd1);

    // Random request/decode backpressure with occasional redirects.
    do_reset(2);
    for (int i = 0; i < 200; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      rnd            = $urandom;
      redirect_pc    = {rnd[31:2], 2'b00};
      cycle();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;

`ifdef FETCH_PERF_COUNTERS_EN
    do_reset(1);
    delivered = 0;
    for (int i = 0; i < 30; i++) begin
      out_ready = (delivered < 8);
      cycle();
    end
    out_ready = 1'b0;
    redirect_pc = 32'h0000_0400;
    redirect_valid = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    redirect_valid = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("perf_delivered", 32'(delivered), 32'd8);
    check("perf_fetched", perf_fetched, 32'd8);
    check("perf_flush", perf_flush, 32'd2);
    check("perf_stall_nonzero", 32'(perf_stall != 0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
